// File: rtl/file_source_sched_if.sv
// Stream and settings bundle between the playback scheduler and its neighbours.
// Latency: n/a (wires only).
// Backpressure: tready travels against the flow on both the input and output streams.
interface file_source_sched_if;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        running;
  logic [31:0] pkt_count;
  logic        done;

  // Scheduler side
  modport slave (
    input  set_stb, set_addr, set_data,
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid,
    output running, pkt_count, done
  );

  // Environment side: settings writer, upstream source and downstream sink
  modport master (
    output set_stb, set_addr, set_data,
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid,
    input  running, pkt_count, done
  );
endinterface

// File: rtl/file_source_sched.sv
// Playback scheduler: start/stop, packet-count limit and idle gap, gated only on packet boundaries.
// Latency: zero-cycle combinational pass-through of data/last/valid/ready while passing.
// Backpressure: upstream is held (tready low) outside PASS; o_tready passes straight to i_tready in PASS.
module file_source_sched #(
  parameter logic [7:0] SR_CTRL     = 8'd132,
  parameter logic [7:0] SR_NUM_PKTS = 8'd133,
  parameter logic [7:0] SR_GAP      = 8'd134
) (
  input  logic             clk,
  input  logic             reset,
  file_source_sched_if.slave s
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]  state;
  logic [31:0] num_pkts;
  logic [15:0] gap;
  logic [15:0] gap_cnt;
  logic [31:0] pkt_count_r;
  logic        stop_pend;
  logic        done_r;

  logic        ctrl_wr;
  logic        start_cmd;
  logic        stop_cmd;
  logic        beat;
  logic        last_beat;
  logic [31:0] pkt_next;
  logic        run_end;

  // Control writes are one-shot strobes; stop beats start when both are set.
  assign ctrl_wr   = s.set_stb && (s.set_addr == SR_CTRL);
  assign stop_cmd  = ctrl_wr && s.set_data[1];
  assign start_cmd = ctrl_wr && s.set_data[0] && !s.set_data[1];

  assign s.o_tdata  = s.i_tdata;
  assign s.o_tlast  = s.i_tlast;
  assign s.o_tvalid = (state == PASS) && s.i_tvalid;
  assign s.i_tready = (state == PASS) && s.o_tready;

  assign beat      = s.o_tvalid && s.o_tready;
  assign last_beat = beat && s.i_tlast;
  assign pkt_next  = pkt_count_r + 32'd1;
  // A stop landing on the final beat itself also ends the run at this boundary.
  assign run_end   = stop_pend || stop_cmd ||
                     ((num_pkts != 32'd0) && (pkt_next >= num_pkts));

  assign s.running   = (state != IDLE);
  assign s.pkt_count = pkt_count_r;
  assign s.done      = done_r;

  // Settings registers; new values apply from the next packet boundary that reads them.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_pkts <= 32'd0;
      gap      <= 16'd0;
    end else if (s.set_stb) begin
      if (s.set_addr == SR_NUM_PKTS) num_pkts <= s.set_data;
      if (s.set_addr == SR_GAP)      gap      <= s.set_data[15:0];
    end
  end

  // Playback state machine, packet counter and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pkt_count_r <= 32'd0;
      stop_pend   <= 1'b0;
      gap_cnt     <= 16'd0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start_cmd) begin
            state       <= PASS;
            pkt_count_r <= 32'd0;
            stop_pend   <= 1'b0;
          end
        end
        PASS: begin
          if (stop_cmd) stop_pend <= 1'b1;
          if (last_beat) begin
            pkt_count_r <= pkt_next;
            if (run_end) begin
              state  <= IDLE;
              done_r <= 1'b1;
            end else if (gap != 16'd0) begin
              state   <= GAP;
              gap_cnt <= gap;
            end
          end
        end
        GAP: begin
          if (stop_cmd) begin
            state   <= IDLE;
            done_r  <= 1'b1;
            gap_cnt <= 16'd0;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
            if (gap_cnt == 16'd1) state <= PASS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_file_source_sched.sv
// Directed bench for file_source_sched with a beat scoreboard.
// Latency: checks sampled on the falling edge and 2 time units after the rising edge.
// Backpressure: source and sink can be switched between always-on and random handshakes.
module tb_file_source_sched;

  localparam logic [7:0] SR_CTRL     = 8'd132;
  localparam logic [7:0] SR_NUM_PKTS = 8'd133;
  localparam logic [7:0] SR_GAP      = 8'd134;

  logic clk = 1'b0;
  logic reset;

  file_source_sched_if sif();

  file_source_sched dut (
    .clk   (clk),
    .reset (reset),
    .s     (sif)
  );

  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int beats_seen = 0;
  int done_cnt   = 0;
  int done_cyc   = 0;
  int src_seq    = 0;
  bit src_rand   = 1'b0;
  bit snk_rand   = 1'b0;
  bit in_fire    = 1'b0;
  logic [64:0] exp_q[$];
  int          beat_cyc[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] dat_of(int seq);
    return {32'hDA7A_0000, 32'(seq)};
  endfunction

  function automatic logic last_of(int seq);
    return (seq % 4) == 3;
  endfunction

  function automatic int cyc_at(int i);
    if (i < beat_cyc.size()) return beat_cyc[i];
    return -1000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    sif.set_stb  = 1'b1;
    sif.set_addr = a;
    sif.set_data = d;
    tick;
    sif.set_stb  = 1'b0;
  endtask

  // Scoreboard entries are the beats the source will offer next, in order.
  task automatic expect_beats(input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({last_of(src_seq + k), dat_of(src_seq + k)});
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    int d = done_cnt;
    while (done_cnt == d && n < budget) begin
      tick;
      n++;
    end
    chk(tag, 64'(done_cnt != d), 64'd1);
  endtask

  task automatic wait_beats(input int target, input int budget, input string tag);
    int n = 0;
    while (beats_seen < target && n < budget) begin
      tick;
      n++;
    end
    chk(tag, 64'(beats_seen >= target), 64'd1);
  endtask

  // Upstream source: sequential data, 4-beat packets, valid sticky until accepted.
  initial begin
    sif.i_tvalid = 1'b0;
    sif.i_tdata  = 64'd0;
    sif.i_tlast  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (in_fire) src_seq++;
      if (src_rand) begin
        if (!sif.i_tvalid || in_fire) sif.i_tvalid = ($urandom_range(0, 1) == 1);
      end else begin
        sif.i_tvalid = 1'b1;
      end
      sif.i_tdata = dat_of(src_seq);
      sif.i_tlast = last_of(src_seq);
    end
  end

  // Downstream sink ready.
  initial begin
    sif.o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sif.o_tready = snk_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: handshakes, scoreboard compare, done pulses.
  always @(negedge clk) begin
    in_fire = sif.i_tvalid && sif.i_tready;
    if (sif.o_tvalid === 1'b1 && sif.o_tready === 1'b1) begin
      logic [64:0] e;
      beat_cyc.push_back(cyc);
      beats_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", sif.o_tdata, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", sif.o_tdata, e[63:0]);
        chk("beat_last", 64'(sif.o_tlast), 64'(e[64]));
      end
    end
    if (sif.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int d0;
    reset        = 1'b1;
    sif.set_stb  = 1'b0;
    sif.set_addr = 8'd0;
    sif.set_data = 32'd0;
    repeat (3) tick;
    reset = 1'b0;
    tick;

    // Reset state, with upstream offering data
    chk("reset_running",   64'(sif.running),  64'd0);
    chk("reset_done",      64'(sif.done),     64'd0);
    chk("reset_o_tvalid",  64'(sif.o_tvalid), 64'd0);
    chk("reset_i_tready",  64'(sif.i_tready), 64'd0);
    chk("reset_pkt_count", 64'(sif.pkt_count), 64'd0);

    // 1: three back-to-back packets
    wr(SR_NUM_PKTS, 32'd3);
    wr(SR_GAP, 32'd0);
    beat_cyc.delete(); b0 = beats_seen; d0 = done_cnt;
    expect_beats(12);
    wr(SR_CTRL, 32'd1);
    wait_done(200, "t1_done_timeout");
    repeat (3) tick;
    chk("t1_beats",      64'(beats_seen - b0), 64'd12);
    chk("t1_queue",      64'(exp_q.size()), 64'd0);
    chk("t1_contiguous", 64'(cyc_at(11) - cyc_at(0)), 64'd11);
    chk("t1_done_cycle", 64'(done_cyc - cyc_at(11)), 64'd1);
    chk("t1_done_once",  64'(done_cnt - d0), 64'd1);
    chk("t1_pkt_count",  64'(sif.pkt_count), 64'd3);
    chk("t1_i_tready",   64'(sif.i_tready), 64'd0);
    chk("t1_running",    64'(sif.running), 64'd0);

    // 2: two packets with a 5-cycle gap
    wr(SR_NUM_PKTS, 32'd2);
    wr(SR_GAP, 32'd5);
    beat_cyc.delete(); b0 = beats_seen;
    expect_beats(8);
    wr(SR_CTRL, 32'd1);
    wait_done(200, "t2_done_timeout");
    repeat (3) tick;
    chk("t2_beats",      64'(beats_seen - b0), 64'd8);
    chk("t2_pkt1_contig", 64'(cyc_at(3) - cyc_at(0)), 64'd3);
    chk("t2_gap",        64'(cyc_at(4) - cyc_at(3)), 64'd6);
    chk("t2_done_cycle", 64'(done_cyc - cyc_at(7)), 64'd1);
    chk("t2_pkt_count",  64'(sif.pkt_count), 64'd2);
    chk("t2_running",    64'(sif.running), 64'd0);

    // 3: continuous, stop on beat 2 of packet 7
    wr(SR_NUM_PKTS, 32'd0);
    wr(SR_GAP, 32'd0);
    beat_cyc.delete(); b0 = beats_seen; d0 = done_cnt;
    expect_beats(28);
    wr(SR_CTRL, 32'd1);
    wait_beats(b0 + 25, 500, "t3_beats_timeout");
    wr(SR_CTRL, 32'd2);
    wait_done(100, "t3_done_timeout");
    repeat (10) tick;
    chk("t3_beats",      64'(beats_seen - b0), 64'd28);
    chk("t3_queue",      64'(exp_q.size()), 64'd0);
    chk("t3_done_cycle", 64'(done_cyc - cyc_at(27)), 64'd1);
    chk("t3_done_once",  64'(done_cnt - d0), 64'd1);
    chk("t3_pkt_count",  64'(sif.pkt_count), 64'd7);
    chk("t3_running",    64'(sif.running), 64'd0);

    // 4: stop during the third gap cycle
    wr(SR_GAP, 32'd10);
    beat_cyc.delete(); b0 = beats_seen; d0 = done_cnt;
    expect_beats(4);
    wr(SR_CTRL, 32'd1);
    wait_beats(b0 + 4, 100, "t4_beats_timeout");
    tick;
    tick;
    wr(SR_CTRL, 32'd2);
    repeat (20) tick;
    chk("t4_done_once",  64'(done_cnt - d0), 64'd1);
    chk("t4_done_cycle", 64'(done_cyc - cyc_at(3)), 64'd4);
    chk("t4_beats",      64'(beats_seen - b0), 64'd4);
    chk("t4_pkt_count",  64'(sif.pkt_count), 64'd1);
    chk("t4_running",    64'(sif.running), 64'd0);

    // 5: random backpressure on both sides
    wr(SR_NUM_PKTS, 32'd5);
    wr(SR_GAP, 32'd2);
    src_rand = 1'b1;
    snk_rand = 1'b1;
    beat_cyc.delete(); b0 = beats_seen;
    expect_beats(20);
    wr(SR_CTRL, 32'd1);
    wait_done(3000, "t5_done_timeout");
    repeat (3) tick;
    chk("t5_beats",     64'(beats_seen - b0), 64'd20);
    chk("t5_queue",     64'(exp_q.size()), 64'd0);
    chk("t5_pkt_count", 64'(sif.pkt_count), 64'd5);
    chk("t5_running",   64'(sif.running), 64'd0);
    src_rand = 1'b0;
    snk_rand = 1'b0;
    repeat (3) tick;

    // 6a: foreign address, then start+stop together, both leave it idle
    b0 = beats_seen; d0 = done_cnt;
    wr(8'd135, 32'd1);
    repeat (3) tick;
    chk("t6_foreign_addr", 64'(sif.running), 64'd0);
    wr(SR_CTRL, 32'd3);
    repeat (5) tick;
    chk("t6_startstop_running", 64'(sif.running), 64'd0);
    chk("t6_startstop_beats",   64'(beats_seen - b0), 64'd0);
    chk("t6_startstop_done",    64'(done_cnt - d0), 64'd0);
    chk("t6_startstop_count",   64'(sif.pkt_count), 64'd5);

    // 6b: reset in the middle of the second packet
    wr(SR_NUM_PKTS, 32'd0);
    wr(SR_GAP, 32'd0);
    b0 = beats_seen;
    expect_beats(7);
    wr(SR_CTRL, 32'd1);
    wait_beats(b0 + 6, 100, "t6_beats_timeout");
    chk("t6_pre_reset_count", 64'(sif.pkt_count), 64'd1);
    reset = 1'b1;
    tick;
    chk("t6_reset_o_tvalid", 64'(sif.o_tvalid), 64'd0);
    chk("t6_reset_running",  64'(sif.running), 64'd0);
    chk("t6_reset_count",    64'(sif.pkt_count), 64'd0);
    reset = 1'b0;
    repeat (5) tick;
    chk("t6_reset_beats", 64'(beats_seen - b0), 64'd7);
    chk("t6_reset_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
